input_stream_reader: RTL and testbench
======================================

INPUT_STREAM_READER -- requirements
Module: input_stream_reader

Interface
REQ-001 SHALL have parameter RD_DATA_WIDTH, default DATA_WIDTH, width of buffer words and stream data.
REQ-002 SHALL have parameter RD_ADDR_WIDTH, default ADDR_WIDTH, width of buffer read address.
REQ-003 SHALL have port clk input 1: clock, all state on posedge.
REQ-004 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start input 1: one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr input RD_ADDR_WIDTH: first buffer address of the burst, sampled with start.
REQ-007 SHALL have port length input RD_ADDR_WIDTH+1: word count, 0 to 2^RD_ADDR_WIDTH, sampled with start.
REQ-008 SHALL have port busy output 1: high in every state except IDLE.
REQ-009 SHALL have port done output 1: one-cycle pulse at burst completion.
REQ-010 SHALL have port rd_en output 1: buffer read enable.
REQ-011 SHALL have port rd_addr output RD_ADDR_WIDTH: buffer read address.
REQ-012 SHALL have port rd_data input RD_DATA_WIDTH: buffer registered read data, valid the cycle after rd_en.
REQ-013 SHALL have port out_valid output 1: stream data valid.
REQ-014 SHALL have port out_ready input 1: downstream accepts when high with out_valid.
REQ-015 SHALL have port out_data output RD_DATA_WIDTH: stream payload.
REQ-016 SHALL have port out_last output 1: marks the final beat of the burst.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN.
- IDLE->RUN: start=1 and length!=0.
- IDLE->DONE pulse, stay IDLE: start=1 and length=0; done high next cycle; no rd_en, no beats.
- RUN->DRAIN: cycle the final read is issued.
- DRAIN->IDLE: cycle the out_last beat is accepted; done=1 that same cycle.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL increment rd_addr by 1 per issued read, wrapping modulo 2^RD_ADDR_WIDTH (e.g. 0xFF->0x00 for width 8).
REQ-020 SHALL hold a 2-entry output FIFO capturing rd_data in the cycle after each rd_en.
REQ-021 SHALL assert rd_en only in RUN when (fifo_count + rd_en_q - pop) < 2, where rd_en_q is the previous cycle's rd_en and pop = out_valid & out_ready.
REQ-022 SHALL never overflow the FIFO nor drop or duplicate a word under any out_ready pattern.
REQ-023 SHALL drive out_valid = (fifo_count != 0) and out_data from the FIFO head; both held stable while out_valid & !out_ready.
REQ-024 SHALL assert out_last with the beat carrying the length-th word only.
REQ-025 SHALL give latency: start at edge T -> rd_en in cycle T+1 -> out_valid in cycle T+3.
REQ-026 SHALL sustain one beat per cycle while out_ready is held high.
REQ-027 SHALL deliver words in address order base_addr, base_addr+1, ...

Reset
REQ-028 SHALL, on rst_n low, asynchronously set state IDLE, busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_last=0, fifo_count=0, rd_en_q=0.
REQ-029 SHALL, on reset mid-burst, discard all in-flight and queued words; no beat or done after release until a new start.

Structure
REQ-030 SHALL take DATA_WIDTH and ADDR_WIDTH from GLOBAL_PARAMS.vh; FSM state enum SHALL live in the shared package.
REQ-031 SHALL implement the 2-entry FIFO as sub-module stream_skid_fifo (push, pop, count, head data).

Verification
REQ-032 SHALL cover: preload buffer addr k = k+0x10; start base=4 len=4, out_ready=1 -> beats 0x14,0x15,0x16,0x17, last on 0x17, out_valid first at T+3, done with last acceptance.
REQ-033 SHALL cover: len=0 -> done one cycle later, rd_en never high, out_valid never high.
REQ-034 SHALL cover: base=0xFE len=4 (width 8) -> reads 0xFE,0xFF,0x00,0x01 in order.
REQ-035 SHALL cover: len=16, out_ready random 30% -> 16 ordered words, no overflow, data stable while stalled.
REQ-036 SHALL cover: start pulsed during RUN with different base -> ignored, original burst completes unchanged.
REQ-037 SHALL cover: rst_n low after 3 beats of len=8 -> all outputs 0 immediately; after release no beats until new start.

Source files
------------

// File: rtl/input_stream_reader_pkg.sv
// Shared widths and FSM encoding for the buffer-to-stream reader.
// Pure declarations: no latency, no flow control.
package input_stream_reader_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO holding buffer words until the stream accepts them.
// Push visible at head the cycle after; caller must never push when full without a pop.
module stream_skid_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/input_stream_reader.sv
// Reads a burst of words from a registered-output buffer and streams them out.
// start->out_valid 3 cycles; reads throttle so the 2-entry FIFO never overflows under out_ready stalls.
module input_stream_reader
    import input_stream_reader_pkg::*;
#(
    parameter int RD_DATA_WIDTH = DATA_WIDTH,
    parameter int RD_ADDR_WIDTH = ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RD_ADDR_WIDTH-1:0] base_addr,
    input  logic [RD_ADDR_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [RD_ADDR_WIDTH-1:0] rd_addr,
    input  logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RD_DATA_WIDTH-1:0] out_data,
    output logic                     out_last
);

    localparam logic [RD_ADDR_WIDTH:0]   CNT_ONE  = {{RD_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [RD_ADDR_WIDTH-1:0] ADDR_ONE = {{(RD_ADDR_WIDTH-1){1'b0}}, 1'b1};

    rd_state_e                state;
    logic [RD_ADDR_WIDTH-1:0] addr_q;
    logic [RD_ADDR_WIDTH:0]   reads_left;
    logic [RD_ADDR_WIDTH:0]   beats_left;
    logic                     rd_en_q;
    logic                     done_q;
    logic [1:0]               fifo_count;
    logic                     pop;
    logic [2:0]               occupancy;

    assign pop       = out_valid & out_ready;
    // Words already queued plus the one landing next cycle, less what leaves now.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_en_q} - {2'b00, pop};
    assign rd_en     = (state == ST_RUN) && (occupancy < 3'd2);

    assign rd_addr   = addr_q;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (fifo_count != 2'd0);
    assign out_last  = out_valid && (beats_left == CNT_ONE);
    assign done      = done_q | ((state == ST_DRAIN) & pop & out_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            reads_left <= '0;
            beats_left <= '0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_en_q <= rd_en;
            done_q  <= 1'b0;
            if (pop) beats_left <= beats_left - CNT_ONE;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state      <= ST_RUN;
                            addr_q     <= base_addr;
                            reads_left <= length;
                            beats_left <= length;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_en) begin
                        addr_q     <= addr_q + ADDR_ONE;
                        reads_left <= reads_left - CNT_ONE;
                        if (reads_left == CNT_ONE) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    stream_skid_fifo #(
        .WIDTH(RD_DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_en_q),
        .push_data(rd_data),
        .pop      (pop),
        .count    (fifo_count),
        .head_data(out_data)
    );

endmodule

// File: tb/tb_input_stream_reader.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor pops and compares.
module tb_input_stream_reader;

    localparam int DW = 16;
    localparam int AW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] mem [256];
    beat_t         sb [$];
    int            errors = 0;
    int            checks = 0;
    int            beats_seen = 0;
    bit            zl_window = 1'b0;

    always #5 clk = ~clk;

    input_stream_reader #(
        .RD_DATA_WIDTH(DW),
        .RD_ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    // Buffer model: registered read, word k holds k+0x10.
    initial for (int k = 0; k < 256; k++) mem[k] = DW'(k + 'h10);
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        sb.push_back(b);
    endtask

    task automatic push_exp(input logic [AW-1:0] base, input int len);
        for (int i = 0; i < len; i++)
            push_beat(DW'(base + AW'(i)) + DW'('h10), i == len - 1);
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input logic [AW:0] len);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; length = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats still pending after %0d cycles, required 0", name, sb.size(), budget);
        end
    endtask

    // Monitor: pops on every accepted beat, checks stall stability and stray done.
    initial begin
        logic pv, pr, pl;
        logic [DW-1:0] pd;
        beat_t e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr) begin
                    check("stall_valid", out_valid, 1);
                    if (out_valid) begin
                        check("stall_data", out_data, pd);
                        check("stall_last", out_last, pl);
                    end
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: data %0h accepted, none expected", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_last", out_last, e.last);
                        check("done_with_last", done, e.last);
                        beats_seen++;
                    end
                end else if (done && !zl_window) begin
                    checks++; errors++;
                    $display("FAIL spurious_done: done=1 without last acceptance, required 0");
                end
                pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            end else begin
                pv = 1'b0;
            end
        end
    end

    initial begin
        int first_valid;
        int n;
        int b0;
        logic [AW-1:0] addrs [$];
        logic [AW-1:0] exp_addr [4];

        // Reset state
        #23;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        @(negedge clk); rst_n = 1'b1;

        // Burst base=4 len=4 with full throughput and latency
        out_ready = 1'b1;
        push_beat(16'h0014, 1'b0);
        push_beat(16'h0015, 1'b0);
        push_beat(16'h0016, 1'b0);
        push_beat(16'h0017, 1'b1);
        pulse_start(8'h04, 9'd4);
        first_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("t1_rd_en_T1", rd_en, 1);
                check("t1_rd_addr_T1", rd_addr, 8'h04);
            end
            if (out_valid && first_valid == 0) first_valid = k;
        end
        check("t1_first_valid_cycle", first_valid, 3);
        wait_idle("t1", 50);

        // Zero-length burst
        zl_window = 1'b1;
        pulse_start(8'h30, 9'd0);
        @(negedge clk);
        check("t2_done_next", done, 1);
        check("t2_busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
            check("t2_quiet", {rd_en, out_valid}, 0);
            @(negedge clk);
            check("t2_done_single", done, 0);
        end
        zl_window = 1'b0;

        // Address wrap at top of the buffer
        push_beat(16'h010E, 1'b0);
        push_beat(16'h010F, 1'b0);
        push_beat(16'h0010, 1'b0);
        push_beat(16'h0011, 1'b1);
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
        pulse_start(8'hFE, 9'd4);
        addrs.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rd_en) addrs.push_back(rd_addr);
        end
        check("t3_read_count", addrs.size(), 4);
        for (int k = 0; k < 4 && k < addrs.size(); k++) check("t3_rd_addr", addrs[k], exp_addr[k]);
        wait_idle("t3", 50);

        // len=16 with ~30% out_ready
        out_ready = 1'b0;
        push_exp(8'h50, 16);
        pulse_start(8'h50, 9'd16);
        n = 0;
        while ((sb.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 99) < 30);
            n++;
        end
        out_ready = 1'b1;
        check("t4_drained", sb.size(), 0);
        wait_idle("t4", 50);

        // start while busy is ignored
        push_exp(8'h40, 6);
        pulse_start(8'h40, 9'd6);
        @(posedge clk); #1;
        check("t5_busy_at_restart", busy, 1);
        start = 1'b1; base_addr = 8'h80; length = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("t5", 50);
        repeat (6) @(negedge clk);
        check("t5_idle_after", busy, 0);

        // Reset mid-burst after 3 beats
        b0 = beats_seen;
        push_exp(8'h20, 8);
        pulse_start(8'h20, 9'd8);
        n = 0;
        while (beats_seen < b0 + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("t6_three_beats", beats_seen - b0, 3);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_rd_en", rd_en, 0);
        check("t6_rst_rd_addr", rd_addr, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_last", out_last, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t6_quiet_after_release", {busy, out_valid, rd_en, done}, 0);
        end
        push_exp(8'h60, 3);
        pulse_start(8'h60, 9'd3);
        wait_idle("t6_new", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
